// File: rtl/trap_int_arbiter_pkg.sv
// trap_int_arbiter_pkg: shared limits and arbiter FSM state encoding
package trap_int_arbiter_pkg;
  localparam int MAX_INTS = 64;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_ACK} arbState_t;
endpackage

// File: rtl/trap_int_arbiter_int_prio_tree.sv
// int_prio_tree: log2-depth max-priority reduction, lower index wins ties
module int_prio_tree #(
  parameter int N = 16,
  parameter int PRIO_W = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]             valid,
  input  logic [N-1:0][PRIO_W-1:0] prio,
  output logic                     anyValid,
  output logic [PRIO_W-1:0]        winPrio,
  output logic [IW-1:0]            winIdx
);
  localparam int L = $clog2(N);
  localparam int P = 1 << L;
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int W = P >> l;
    logic v [W];
    logic [PRIO_W-1:0] p [W];
    logic [IW-1:0] x [W];
    for (genvar k = 0; k < W; k++) begin : g_n
      if (l == 0 && k < N) begin : g_leaf
        assign v[k] = valid[k];
        assign p[k] = prio[k];
        assign x[k] = IW'(k);
      end else if (l == 0) begin : g_pad
        assign v[k] = 1'b0;
        assign p[k] = '0;
        assign x[k] = '0;
      end else begin : g_node
        logic pickL;
        // left child always holds the lower indices, so >= keeps ties low
        assign pickL = g_lvl[l-1].v[2*k] &&
                       (!g_lvl[l-1].v[2*k+1] || g_lvl[l-1].p[2*k] >= g_lvl[l-1].p[2*k+1]);
        assign v[k] = g_lvl[l-1].v[2*k] | g_lvl[l-1].v[2*k+1];
        assign p[k] = pickL ? g_lvl[l-1].p[2*k] : g_lvl[l-1].p[2*k+1];
        assign x[k] = pickL ? g_lvl[l-1].x[2*k] : g_lvl[l-1].x[2*k+1];
      end
    end
  end
  assign anyValid = g_lvl[L].v[0];
  assign winPrio  = g_lvl[L].p[0];
  assign winIdx   = g_lvl[L].x[0];
endmodule

// File: rtl/trap_int_arbiter.sv
// trap_int_arbiter: prioritised M/S interrupt arbiter with registered request and take handshake
module trap_int_arbiter
  import trap_int_arbiter_pkg::*;
#(
  parameter int NUM_INTS = 16,
  parameter int PRIO_W = 3,
  parameter logic [NUM_INTS-1:0] EDGE_MASK = '0,
  parameter bit S_SUPPORTED = 1'b1,
  localparam int IW = $clog2(NUM_INTS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_INTS-1:0] IntSrc,
  input  logic [NUM_INTS-1:0] IntEn,
  input  logic [NUM_INTS-1:0] IntDeleg,
  input  logic                PrioWrEn,
  input  logic [IW-1:0]       PrioWrIdx,
  input  logic [PRIO_W-1:0]   PrioWrData,
  input  logic [1:0]          PrivilegeModeW,
  input  logic                STATUS_MIE,
  input  logic                STATUS_SIE,
  input  logic                InstrValidM,
  input  logic                CommittedM,
  input  logic                CommittedF,
  input  logic                TakeM,
  output logic                IntReqM,
  output logic [IW-1:0]       IntCauseM,
  output logic                IntDelegateM,
  output logic [NUM_INTS-1:0] PendingM,
  output logic                IntPendingM
);
  if (NUM_INTS < 2 || NUM_INTS > MAX_INTS) begin : g_badNumInts
    $error("NUM_INTS out of range");
  end
  arbState_t state, nextState;
  logic [IW-1:0] cause, nextCause, mIdx, sIdx, winIdx;
  logic deleg, nextDeleg, mEn, sEn, mAny, sAny, winValid, winDeleg, latchedElig, higher, take;
  logic [NUM_INTS-1:0] srcQ, pendEdge, cand, mValid, sValid, effDeleg, clr;
  logic [NUM_INTS-1:0][PRIO_W-1:0] prio;
  logic [PRIO_W-1:0] mPrio, sPrio, winPrio;
  assign PendingM = (EDGE_MASK & pendEdge) | (~EDGE_MASK & srcQ);
  assign IntPendingM = |(PendingM & IntEn);
  for (genvar i = 0; i < NUM_INTS; i++) begin : g_cand
    assign cand[i] = PendingM[i] & IntEn[i] & |prio[i];
  end
  assign effDeleg = S_SUPPORTED ? IntDeleg : '0;
  assign mEn = (PrivilegeModeW != 2'b11) | STATUS_MIE;
  assign sEn = S_SUPPORTED & ((PrivilegeModeW == 2'b00) | ((PrivilegeModeW == 2'b01) & STATUS_SIE));
  assign mValid = cand & ~effDeleg & {NUM_INTS{mEn}};
  assign sValid = cand & effDeleg & {NUM_INTS{sEn}};
  int_prio_tree #(.N(NUM_INTS), .PRIO_W(PRIO_W)) mTree (
    .valid(mValid), .prio(prio), .anyValid(mAny), .winPrio(mPrio), .winIdx(mIdx));
  int_prio_tree #(.N(NUM_INTS), .PRIO_W(PRIO_W)) sTree (
    .valid(sValid), .prio(prio), .anyValid(sAny), .winPrio(sPrio), .winIdx(sIdx));
  assign winValid = mAny | sAny;
  assign winDeleg = ~mAny;
  assign winPrio = mAny ? mPrio : sPrio;
  assign winIdx = mAny ? mIdx : sIdx;
  // eligibility is judged in the class the source was latched in
  assign latchedElig = deleg ? sValid[cause] : mValid[cause];
  assign higher = winValid & ((deleg & ~winDeleg) | ((deleg == winDeleg) & (winPrio > prio[cause])));
  assign take = TakeM & IntReqM;
  assign clr = {{(NUM_INTS-1){1'b0}}, take} << cause;
  assign IntCauseM = cause;
  assign IntDelegateM = deleg & S_SUPPORTED & (PrivilegeModeW != 2'b11);
  always_comb begin
    nextState = state;
    nextCause = cause;
    nextDeleg = deleg;
    IntReqM = 1'b0;
    if (state == ARB_IDLE) begin
      if (winValid) begin
        nextState = ARB_REQ;
        nextCause = winIdx;
        nextDeleg = winDeleg;
      end
    end else if (state == ARB_REQ) begin
      IntReqM = latchedElig & InstrValidM & ~CommittedM & ~CommittedF;
      if (!latchedElig) nextState = ARB_IDLE;
      else if (TakeM & IntReqM) nextState = ARB_ACK;
      else if (higher) begin
        nextCause = winIdx;
        nextDeleg = winDeleg;
      end
    end else nextState = ARB_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      cause <= '0;
      deleg <= 1'b0;
      srcQ <= '0;
      pendEdge <= '0;
      prio <= {NUM_INTS{PRIO_W'(1)}};
    end else begin
      state <= nextState;
      cause <= nextCause;
      deleg <= nextDeleg;
      srcQ <= IntSrc;
      pendEdge <= EDGE_MASK & ((pendEdge & ~clr) | (IntSrc & ~srcQ));
      if (PrioWrEn) prio[PrioWrIdx] <= PrioWrData;
    end
  end
endmodule
